// File: rtl/sequenciador_multiciclo_pkg.sv
// Shared encodings for the multicycle control sequencer.
// Covers states, opcodes, ALU operation codes and register select constants.
package sequenciador_multiciclo_pkg;

   localparam int unsigned IR_W    = 9;
   localparam int unsigned REG_N   = 8;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned ULA_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 3'd0,
      S_F1   = 3'd1,
      S_F2   = 3'd2,
      S_F3   = 3'd3,
      S_E1   = 3'd4,
      S_E2   = 3'd5,
      S_E3   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      OP_MV   = 3'b000,
      OP_MVI  = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_LD   = 3'b100,
      OP_ST   = 3'b101,
      OP_MVNZ = 3'b110,
      OP_NOP  = 3'b111
   } opcode_t;

   localparam logic [ULA_W-1:0] ULA_ADD = 2'b00;
   localparam logic [ULA_W-1:0] ULA_SUB = 2'b01;

   // Register select bit 0 is R7, the program counter.
   localparam logic [REG_N-1:0] PC_SEL   = {{(REG_N-1){1'b0}}, 1'b1};
   localparam logic [REG_N-1:0] R0_SEL   = {1'b1, {(REG_N-1){1'b0}}};

   // Instructions that finish in E1.
   function automatic logic is_short_op(input opcode_t op);
      return (op == OP_MV) || (op == OP_MVNZ) || (op == OP_NOP);
   endfunction

endpackage

// File: rtl/sequenciador_multiciclo_decod3_8.sv
// Register index to reversed onehot select: index 0 maps to bit 7 (R0), index 7 to bit 0 (PC).
module decod3_8
   import sequenciador_multiciclo_pkg::*;
(
   input  logic [2:0]       idx,
   output logic [REG_N-1:0] onehot
);

   always_comb begin
      onehot = R0_SEL >> idx;
   end

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multicycle control sequencer: fetch (F1-F3) then up to three execute states.
// Outputs are decoded from the state register and IR; only mvnz enables look at Gnz.
module sequenciador_multiciclo
   import sequenciador_multiciclo_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Run,
   input  logic [IR_W-1:0]     Instrucao,
   input  logic                Gnz,
   output logic                IRin,
   output logic [REG_N-1:0]    Rin,
   output logic [REG_N-1:0]    Rout,
   output logic                Ain,
   output logic                Gin,
   output logic                Gout,
   output logic                DINout,
   output logic [ULA_W-1:0]    Ulaop,
   output logic                ADDRin,
   output logic                DOUTin,
   output logic                W_D,
   output logic                IncrPc,
   output logic                Done,
   output logic [STATE_W-1:0]  Estado
);

   state_t           state;
   state_t           state_next;
   opcode_t          opcode;
   logic [REG_N-1:0] x_sel;
   logic [REG_N-1:0] y_sel;

   assign opcode = opcode_t'(Instrucao[8:6]);
   assign Estado = state;

   decod3_8 u_dec_x (.idx(Instrucao[5:3]), .onehot(x_sel));
   decod3_8 u_dec_y (.idx(Instrucao[2:0]), .onehot(y_sel));

   always_ff @(posedge Clock) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  state_next = Run ? S_F1 : S_IDLE;
         S_F1:    state_next = S_F2;
         S_F2:    state_next = S_F3;
         S_F3:    state_next = S_E1;
         S_E1: begin
            if (is_short_op(opcode)) state_next = Run ? S_F1 : S_IDLE;
            else                     state_next = S_E2;
         end
         S_E2:    state_next = S_E3;
         S_E3:    state_next = Run ? S_F1 : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      IRin   = 1'b0;
      Rin    = '0;
      Rout   = '0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      DINout = 1'b0;
      Ulaop  = ULA_ADD;
      ADDRin = 1'b0;
      DOUTin = 1'b0;
      W_D    = 1'b0;
      IncrPc = 1'b0;
      Done   = 1'b0;
      case (state)
         S_F1: begin
            Rout   = PC_SEL;
            ADDRin = 1'b1;
            IncrPc = 1'b1;
         end
         S_F3: IRin = 1'b1;
         S_E1: begin
            case (opcode)
               OP_MV: begin
                  Rout = y_sel;
                  Rin  = x_sel;
                  Done = 1'b1;
               end
               OP_MVI: begin
                  Rout   = PC_SEL;
                  ADDRin = 1'b1;
                  IncrPc = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  Rout = x_sel;
                  Ain  = 1'b1;
               end
               OP_LD, OP_ST: begin
                  Rout   = y_sel;
                  ADDRin = 1'b1;
               end
               OP_MVNZ: begin
                  Done = 1'b1;
                  if (Gnz) begin
                     Rout = y_sel;
                     Rin  = x_sel;
                  end
               end
               OP_NOP:  Done = 1'b1;
               default: ;
            endcase
         end
         S_E2: begin
            case (opcode)
               OP_ADD, OP_SUB: begin
                  Rout  = y_sel;
                  Gin   = 1'b1;
                  Ulaop = (opcode == OP_SUB) ? ULA_SUB : ULA_ADD;
               end
               OP_ST: begin
                  Rout   = x_sel;
                  DOUTin = 1'b1;
               end
               default: ;
            endcase
         end
         S_E3: begin
            case (opcode)
               OP_MVI, OP_LD: begin
                  DINout = 1'b1;
                  Rin    = x_sel;
                  Done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  Gout = 1'b1;
                  Rin  = x_sel;
                  Done = 1'b1;
               end
               OP_ST: begin
                  // A reset arriving in the write cycle must not corrupt memory.
                  W_D  = ~Reset;
                  Done = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed self-checking bench for sequenciador_multiciclo.
// Each scenario task walks an instruction cycle by cycle against hand-derived control words.
module tb_sequenciador_multiciclo;

   typedef struct packed {
      logic       irin;
      logic [7:0] rin;
      logic [7:0] rout;
      logic       ain;
      logic       gin;
      logic       gout;
      logic       dinout;
      logic [1:0] ulaop;
      logic       addrin;
      logic       doutin;
      logic       w_d;
      logic       incrpc;
      logic       done;
   } outs_t;

   localparam logic [2:0] ST_IDLE = 3'd0;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Run;
   logic [8:0] Instrucao;
   logic       Gnz;
   logic       IRin, Ain, Gin, Gout, DINout, ADDRin, DOUTin, W_D, IncrPc, Done;
   logic [7:0] Rin, Rout;
   logic [1:0] Ulaop;
   logic [2:0] Estado;
   outs_t      obs;

   int checks = 0;
   int passed = 0;

   sequenciador_multiciclo dut (
      .Clock(Clock), .Reset(Reset), .Run(Run), .Instrucao(Instrucao), .Gnz(Gnz),
      .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
      .DINout(DINout), .Ulaop(Ulaop), .ADDRin(ADDRin), .DOUTin(DOUTin), .W_D(W_D),
      .IncrPc(IncrPc), .Done(Done), .Estado(Estado)
   );

   assign obs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, Ulaop, ADDRin, DOUTin, W_D, IncrPc, Done};

   always #5 Clock = ~Clock;

   task automatic tick;
      @(posedge Clock);
      #2;
   endtask

   // Expected control word for fetch cycle i (0=F1, 1=F2, 2=F3); zero otherwise.
   function automatic outs_t fetch_exp(input int i);
      outs_t e;
      e = '0;
      if (i == 0) begin
         e.rout   = 8'h01;
         e.addrin = 1'b1;
         e.incrpc = 1'b1;
      end else if (i == 2) begin
         e.irin = 1'b1;
      end
      return e;
   endfunction

   task automatic test_reset;
      Reset = 1'b1; Run = 1'b0; Gnz = 1'b0; Instrucao = '0;
      tick;
      checks++;
      if (Estado !== ST_IDLE || obs !== '0)
         $display("FAIL reset: Estado=%0d outs=%h, required Estado=0 outs=0", Estado, obs);
      else passed++;
      Reset = 1'b0;
      tick;
      checks++;
      if (Estado !== ST_IDLE || obs !== '0)
         $display("FAIL idle_hold: Estado=%0d outs=%h, required Estado=0 outs=0", Estado, obs);
      else passed++;
   endtask

   task automatic test_mvi;
      outs_t      e [6];
      logic [2:0] s [6];
      int         incr;
      incr = 0;
      for (int i = 0; i < 6; i++) begin e[i] = fetch_exp(i); s[i] = 3'(i + 1); end
      e[3].rout = 8'h01; e[3].addrin = 1'b1; e[3].incrpc = 1'b1;
      e[5].dinout = 1'b1; e[5].rin = 8'h10; e[5].done = 1'b1;
      Instrucao = 9'b001_011_000; Run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         incr += int'(IncrPc);
         checks++;
         if (obs !== e[i] || Estado !== s[i])
            $display("FAIL mvi cycle %0d: Estado=%0d outs=%h, required Estado=%0d outs=%h", i, Estado, obs, s[i], e[i]);
         else passed++;
         if (i == 5) Run = 1'b0;
      end
      checks++;
      if (incr !== 2) $display("FAIL mvi_incrpc_count: got %0d, required 2", incr);
      else passed++;
      tick;
      checks++;
      if (Estado !== ST_IDLE || obs !== '0)
         $display("FAIL mvi_end_idle: Estado=%0d outs=%h, required Estado=0 outs=0", Estado, obs);
      else passed++;
   endtask

   task automatic test_sub;
      outs_t      e [6];
      logic [2:0] s [6];
      for (int i = 0; i < 6; i++) begin e[i] = fetch_exp(i); s[i] = 3'(i + 1); end
      e[3].rout = 8'h40; e[3].ain = 1'b1;
      e[4].rout = 8'h20; e[4].gin = 1'b1; e[4].ulaop = 2'b01;
      e[5].gout = 1'b1; e[5].rin = 8'h40; e[5].done = 1'b1;
      Instrucao = 9'b011_001_010; Run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         checks++;
         if (obs !== e[i] || Estado !== s[i])
            $display("FAIL sub cycle %0d: Estado=%0d outs=%h, required Estado=%0d outs=%h", i, Estado, obs, s[i], e[i]);
         else passed++;
         if (i == 5) Run = 1'b0;
      end
      tick;
      checks++;
      if (Estado !== ST_IDLE || obs !== '0)
         $display("FAIL sub_end_idle: Estado=%0d outs=%h, required Estado=0 outs=0", Estado, obs);
      else passed++;
   endtask

   task automatic test_mvnz;
      outs_t e [4];
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 4; i++) e[i] = fetch_exp(i);
         e[3].done = 1'b1;
         if (g == 1) begin e[3].rin = 8'h80; e[3].rout = 8'h40; end
         Instrucao = 9'b110_000_001; Gnz = 1'(g); Run = 1'b1;
         for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (obs !== e[i] || Estado !== 3'(i + 1))
               $display("FAIL mvnz gnz=%0d cycle %0d: Estado=%0d outs=%h, required Estado=%0d outs=%h",
                        g, i, Estado, obs, i + 1, e[i]);
            else passed++;
            if (i == 3) Run = 1'b0;
         end
         tick;
         checks++;
         if (Estado !== ST_IDLE || obs !== '0)
            $display("FAIL mvnz_end_idle gnz=%0d: Estado=%0d outs=%h, required Estado=0 outs=0", g, Estado, obs);
         else passed++;
      end
      Gnz = 1'b0;
   endtask

   task automatic test_mv_pc;
      outs_t e [4];
      for (int i = 0; i < 4; i++) e[i] = fetch_exp(i);
      e[3].rin = 8'h01; e[3].rout = 8'h20; e[3].done = 1'b1;
      Instrucao = 9'b000_111_010; Run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++;
         if (obs !== e[i] || Estado !== 3'(i + 1))
            $display("FAIL mv_pc cycle %0d: Estado=%0d outs=%h, required Estado=%0d outs=%h", i, Estado, obs, i + 1, e[i]);
         else passed++;
         if (i == 3) Run = 1'b0;
      end
      tick;
      checks++;
      if (Estado !== ST_IDLE) $display("FAIL mv_pc_end_idle: Estado=%0d, required 0", Estado);
      else passed++;
   endtask

   task automatic test_back_to_back;
      outs_t      e [10];
      logic [2:0] s [10];
      for (int i = 0; i < 6; i++) begin e[i] = fetch_exp(i); s[i] = 3'(i + 1); end
      for (int i = 6; i < 10; i++) begin e[i] = fetch_exp(i - 6); s[i] = 3'(i - 5); end
      e[3].rout = 8'h10; e[3].addrin = 1'b1;
      e[4].rout = 8'h20; e[4].doutin = 1'b1;
      e[5].w_d = 1'b1; e[5].done = 1'b1;
      e[9].done = 1'b1;
      Instrucao = 9'b101_010_011; Run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         checks++;
         if (obs !== e[i] || Estado !== s[i])
            $display("FAIL st_nop cycle %0d: Estado=%0d outs=%h, required Estado=%0d outs=%h", i, Estado, obs, s[i], e[i]);
         else passed++;
         if (i == 5) Instrucao = 9'b111_000_000;
         if (i == 9) Run = 1'b0;
      end
      tick;
      checks++;
      if (Estado !== ST_IDLE || obs !== '0)
         $display("FAIL st_nop_end_idle: Estado=%0d outs=%h, required Estado=0 outs=0", Estado, obs);
      else passed++;
   endtask

   task automatic test_ld_run_drop;
      outs_t      e [6];
      logic [2:0] s [6];
      for (int i = 0; i < 6; i++) begin e[i] = fetch_exp(i); s[i] = 3'(i + 1); end
      e[3].rout = 8'h01; e[3].addrin = 1'b1;
      e[5].dinout = 1'b1; e[5].rin = 8'h02; e[5].done = 1'b1;
      Instrucao = 9'b100_110_111; Run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         checks++;
         if (obs !== e[i] || Estado !== s[i])
            $display("FAIL ld cycle %0d: Estado=%0d outs=%h, required Estado=%0d outs=%h", i, Estado, obs, s[i], e[i]);
         else passed++;
         if (i == 3) Run = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
         tick;
         checks++;
         if (Estado !== ST_IDLE || obs !== '0)
            $display("FAIL ld_end_idle %0d: Estado=%0d outs=%h, required Estado=0 outs=0", k, Estado, obs);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_add;
      outs_t      e [5];
      for (int i = 0; i < 5; i++) e[i] = fetch_exp(i);
      e[3].rout = 8'h08; e[3].ain = 1'b1;
      e[4].rout = 8'h04; e[4].gin = 1'b1; e[4].ulaop = 2'b00;
      Instrucao = 9'b010_100_101; Run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++;
         if (obs !== e[i] || Estado !== 3'(i + 1))
            $display("FAIL add cycle %0d: Estado=%0d outs=%h, required Estado=%0d outs=%h", i, Estado, obs, i + 1, e[i]);
         else passed++;
      end
      Reset = 1'b1;
      tick;
      checks++;
      if (Estado !== ST_IDLE || obs !== '0)
         $display("FAIL add_reset: Estado=%0d outs=%h, required Estado=0 outs=0", Estado, obs);
      else passed++;
      Reset = 1'b0;
      tick;
      checks++;
      if (Estado !== 3'd1 || obs !== fetch_exp(0))
         $display("FAIL add_restart: Estado=%0d outs=%h, required Estado=1 outs=%h", Estado, obs, fetch_exp(0));
      else passed++;
      Run = 1'b0; Reset = 1'b1;
      tick;
      Reset = 1'b0;
      checks++;
      if (Estado !== ST_IDLE) $display("FAIL add_restart_reset: Estado=%0d, required 0", Estado);
      else passed++;
   endtask

   task automatic test_reset_wd;
      outs_t e [6];
      for (int i = 0; i < 6; i++) e[i] = fetch_exp(i);
      e[3].rout = 8'h80; e[3].addrin = 1'b1;
      e[4].rout = 8'h40; e[4].doutin = 1'b1;
      e[5].w_d = 1'b1; e[5].done = 1'b1;
      Instrucao = 9'b101_001_000; Run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         checks++;
         if (obs !== e[i] || Estado !== 3'(i + 1))
            $display("FAIL st_wd cycle %0d: Estado=%0d outs=%h, required Estado=%0d outs=%h", i, Estado, obs, i + 1, e[i]);
         else passed++;
      end
      Run = 1'b0; Reset = 1'b1;
      #1;
      checks++;
      if (W_D !== 1'b0 || Done !== 1'b1 || Estado !== 3'd6)
         $display("FAIL st_wd_suppress: W_D=%b Done=%b Estado=%0d, required W_D=0 Done=1 Estado=6", W_D, Done, Estado);
      else passed++;
      tick;
      Reset = 1'b0;
      checks++;
      if (Estado !== ST_IDLE || obs !== '0)
         $display("FAIL st_wd_idle: Estado=%0d outs=%h, required Estado=0 outs=0", Estado, obs);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_mvi;
      test_sub;
      test_mvnz;
      test_mv_pc;
      test_back_to_back;
      test_ld_run_drop;
      test_reset_mid_add;
      test_reset_wd;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end

endmodule
